// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer for the
// mon_prod Montgomery multiplier. Issues OPXX per exponent bit, OPXM per
// set bit, then OPX1 to leave the Montgomery domain, and reports status.
module mod_exp_ctrl #(
   parameter int EBITS     = 512,
   parameter int LOG_EBITS = 9,
   parameter int BITLEN    = 512,
   parameter int MP_COUNT  = 512,
   parameter int TIMEOUT   = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [EBITS-1:0]     exp_in,
   input  logic [LOG_EBITS:0]   exp_len,
   input  logic                 mp_stop,
   input  logic [BITLEN:0]      mp_P,
   output logic                 mp_start,
   output logic [1:0]           mp_op,
   output logic [9:0]           mp_count,
   output logic                 busy,
   output logic                 done,
   output logic [BITLEN:0]      result,
   output logic [1:0]           err
);

   localparam int WDW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] OPXX = 2'd0;
   localparam logic [1:0] OPXM = 2'd1;
   localparam logic [1:0] OPX1 = 2'd2;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_ABORT   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

   state_t                state_reg, state_next;
   logic [EBITS-1:0]      exp_reg, exp_next;
   logic [LOG_EBITS-1:0]  idx_reg, idx_next;
   logic [1:0]            op_reg, op_next;
   logic                  start_reg, start_next;
   logic                  busy_reg, busy_next;
   logic                  done_reg, done_next;
   logic [BITLEN:0]       result_reg, result_next;
   logic [1:0]            err_reg, err_next;
   logic [BITLEN:0]       p_last_reg, p_last_next;
   logic [WDW-1:0]        wd_reg, wd_next;
   logic [LOG_EBITS:0]    len_clamped;

   // Requested lengths beyond the exponent register are treated as full width.
   assign len_clamped = (exp_len > (LOG_EBITS+1)'(EBITS)) ? (LOG_EBITS+1)'(EBITS) : exp_len;

   assign mp_start = start_reg;
   assign mp_op    = op_reg;
   assign mp_count = 10'(MP_COUNT);
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign result   = result_reg;
   assign err      = err_reg;

   // State and datapath registers; every output comes straight from here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         exp_reg    <= '0;
         idx_reg    <= '0;
         op_reg     <= OPXX;
         start_reg  <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         result_reg <= '0;
         err_reg    <= ERR_OK;
         p_last_reg <= '0;
         wd_reg     <= '0;
      end else begin
         state_reg  <= state_next;
         exp_reg    <= exp_next;
         idx_reg    <= idx_next;
         op_reg     <= op_next;
         start_reg  <= start_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
         result_reg <= result_next;
         err_reg    <= err_next;
         p_last_reg <= p_last_next;
         wd_reg     <= wd_next;
      end
   end

   // Next-state and next-output selection for the sequencer.
   always_comb begin
      state_next  = state_reg;
      exp_next    = exp_reg;
      idx_next    = idx_reg;
      op_next     = op_reg;
      start_next  = 1'b0;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      result_next = result_reg;
      err_next    = err_reg;
      p_last_next = p_last_reg;
      wd_next     = wd_reg;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               exp_next   = exp_in;
               busy_next  = 1'b1;
               state_next = S_ISSUE;
               if (len_clamped == '0) begin
                  op_next = OPX1;
               end else begin
                  idx_next = LOG_EBITS'(len_clamped - 1'b1);
                  op_next  = OPXX;
               end
            end
         end
         S_ISSUE: begin
            start_next = 1'b1;
            wd_next    = '0;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            wd_next = wd_reg + 1'b1;
            // wd_reg==0 is the first WAIT cycle: stop there is still the
            // previous operation's, because mon_prod has not sampled start yet.
            if (wd_reg != '0 && mp_stop) begin
               p_last_next = mp_P;
               state_next  = S_NEXT;
            end else if (wd_reg == WDW'(TIMEOUT - 1)) begin
               err_next   = ERR_TIMEOUT;
               state_next = S_DONE;
            end
         end
         S_NEXT: begin
            if (op_reg == OPX1) begin
               result_next = p_last_reg;
               err_next    = ERR_OK;
               state_next  = S_DONE;
            end else if (abort) begin
               err_next   = ERR_ABORT;
               state_next = S_DONE;
            end else begin
               state_next = S_ISSUE;
               if (op_reg == OPXX && exp_reg[idx_reg]) begin
                  op_next = OPXM;
               end else if (idx_reg == '0) begin
                  op_next = OPX1;
               end else begin
                  idx_next = idx_reg - 1'b1;
                  op_next  = OPXX;
               end
            end
         end
         S_DONE: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural mon_prod that raises
// stop five edges after sampling start and logs every issued op code.
module tb_mod_exp_ctrl;

   localparam int EBITS     = 8;
   localparam int LOG_EBITS = 3;
   localparam int BITLEN    = 16;
   localparam int MP_COUNT  = 512;
   localparam int TIMEOUT   = 16;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic                abort;
   logic [EBITS-1:0]    exp_in;
   logic [LOG_EBITS:0]  exp_len;
   logic                mp_stop = 1'b1;
   logic [BITLEN:0]     mp_P = '0;
   logic                mp_start;
   logic [1:0]          mp_op;
   logic [9:0]          mp_count;
   logic                busy;
   logic                done;
   logic [BITLEN:0]     result;
   logic [1:0]          err;

   int checks = 0;
   int errors = 0;

   // mon_prod model state
   logic [1:0] op_log [0:63];
   int         log_cnt = 0;
   logic [1:0] op_q = 2'd0;
   int         cnt = 0;
   bit         never_stop = 1'b0;

   // per-run observations
   int base;
   int pulses;
   int busy_cyc;
   int done_cnt;
   int stab_bad;

   mod_exp_ctrl #(
      .EBITS(EBITS), .LOG_EBITS(LOG_EBITS), .BITLEN(BITLEN),
      .MP_COUNT(MP_COUNT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .exp_in(exp_in), .exp_len(exp_len), .mp_stop(mp_stop), .mp_P(mp_P),
      .mp_start(mp_start), .mp_op(mp_op), .mp_count(mp_count),
      .busy(busy), .done(done), .result(result), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural mon_prod: no reset, P tags the operation index and op code.
   always @(posedge clk) begin
      if (mp_start) begin
         op_log[log_cnt] <= mp_op;
         log_cnt         <= log_cnt + 1;
         op_q            <= mp_op;
         mp_P            <= 17'(32'h0C000 + log_cnt * 8 + int'(mp_op));
         mp_stop         <= 1'b0;
         cnt             <= 5;
      end else if (cnt != 0) begin
         cnt <= cnt - 1;
         if (cnt == 1 && !never_stop) mp_stop <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_seq(input string tag, input logic [17:0] ops, input int n);
      logic [1:0] want;
      chk({tag, "_pulses"}, 32'(pulses), 32'(n));
      for (int i = 0; i < n; i++) begin
         want = ops[2*i +: 2];
         chk($sformatf("%s_op%0d", tag, i), 32'(op_log[base + i]), 32'(want));
      end
   endtask

   // One exponentiation: pulse start, watch up to 400 cycles, stop 3 cycles after done.
   task automatic run(input string tag, input logic [7:0] e, input logic [3:0] len,
                      input int mid_start, input bit do_abort);
      int post;
      @(negedge clk);
      exp_in  = e;
      exp_len = len;
      start   = 1'b1;
      base    = log_cnt;
      busy_cyc = 0; done_cnt = 0; stab_bad = 0; post = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         start = (c == mid_start || c == mid_start + 12);
         if (start) exp_len = 4'd0;
         if (busy) busy_cyc++;
         if (done) done_cnt++;
         if (busy && !mp_stop && mp_op !== op_q) stab_bad++;
         if (do_abort && log_cnt - base >= 2) abort = 1'b1;
         if (done_cnt > 0) post++;
         if (post > 3) break;
      end
      start  = 1'b0;
      abort  = 1'b0;
      pulses = log_cnt - base;
      $display("run %s e=%0h len=%0d pulses=%0d busy_cycles=%0d done=%0d err=%0d result=%0h",
               tag, e, len, pulses, busy_cyc, done_cnt, err, result);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_in = '0; exp_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_mp_start", 32'(mp_start), 0);
      chk("rst_mp_op",    32'(mp_op),    0);
      chk("rst_busy",     32'(busy),     0);
      chk("rst_done",     32'(done),     0);
      chk("rst_result",   32'(result),   0);
      chk("rst_err",      32'(err),      0);
      chk("mp_count",     32'(mp_count), 512);
      rst_n = 1'b1;

      // 1: e=101, three bits
      run("t1", 8'b101, 4'd3, -100, 1'b0);
      chk_seq("t1", 18'({2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0}), 6);
      chk("t1_done", 32'(done_cnt), 1);
      chk("t1_err", 32'(err), 0);
      chk("t1_result", 32'(result), 32'h0C02A);

      // 2: empty exponent, single OPX1
      run("t2", 8'h00, 4'd0, -100, 1'b0);
      chk_seq("t2", 18'({2'd2}), 1);
      chk("t2_busy_cycles", 32'(busy_cyc), 10);
      chk("t2_done", 32'(done_cnt), 1);
      chk("t2_result", 32'(result), 32'h0C032);

      // 3: all ones, four bits, stray starts mid-run
      run("t3", 8'hFF, 4'd4, 5, 1'b0);
      chk_seq("t3", 18'({2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0}), 9);
      chk("t3_op_stable", 32'(stab_bad), 0);
      chk("t3_done", 32'(done_cnt), 1);
      chk("t3_err", 32'(err), 0);
      chk("t3_result", 32'(result), 32'h0C07A);

      // 4: abort during the second operation
      run("t4", 8'b101, 4'd3, -100, 1'b1);
      chk_seq("t4", 18'({2'd1, 2'd0}), 2);
      chk("t4_done", 32'(done_cnt), 1);
      chk("t4_err", 32'(err), 1);
      chk("t4_result", 32'(result), 32'h0C07A);
      chk("t4_busy", 32'(busy), 0);

      // 6: asynchronous reset in WAIT, then recovery
      @(negedge clk);
      exp_in = 8'b101; exp_len = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_in_wait_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_mp_start", 32'(mp_start), 0);
      chk("t6_rst_mp_op",    32'(mp_op),    0);
      chk("t6_rst_busy",     32'(busy),     0);
      chk("t6_rst_done",     32'(done),     0);
      chk("t6_rst_result",   32'(result),   0);
      chk("t6_rst_err",      32'(err),      0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50 && !mp_stop; i++) @(negedge clk);
      chk("t6_stop_seen", 32'(mp_stop), 1);
      run("t6", 8'h01, 4'd1, -100, 1'b0);
      chk_seq("t6", 18'({2'd2, 2'd1, 2'd0}), 3);
      chk("t6_err", 32'(err), 0);
      chk("t6_result", 32'(result), 32'h0C0AA);

      // 5: mon_prod never stops, watchdog fires
      never_stop = 1'b1;
      run("t5", 8'h01, 4'd1, -100, 1'b0);
      chk_seq("t5", 18'({2'd0}), 1);
      chk("t5_busy_cycles", 32'(busy_cyc), 18);
      chk("t5_done", 32'(done_cnt), 1);
      chk("t5_err", 32'(err), 2);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_result", 32'(result), 32'h0C0AA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
